// File: rtl/pad_in_debounce.sv
// pad_in_debounce
//   Conditions an asynchronous pad input (IOB I output) for use by fabric logic.
//   The raw pad value goes through a synchroniser chain. The synchronised value
//   then has to differ from Q for DEBOUNCE consecutive CE-qualified cycles
//   before Q follows it. A clean level and one-cycle RISE/FALL pulses come out.
//   Place one instance per input pad, directly after the IOB/IBUF.
//
// Handshake/timing: there is no valid/ready handshake. PAD_I is sampled on
//   every rising edge of C. CE is a debounce tick: it only qualifies the
//   counter advance. Q, RISE, FALL and BUSY are all registered outputs.
//
// Ports
//   C      in   clock, rising edge
//   RD     in   asynchronous active-low reset
//   PAD_I  in   raw pad value, asynchronous to C
//   CE     in   debounce tick; the counter advances only when CE=1
//   Q      out  debounced level
//   RISE   out  one-cycle pulse, high in the first cycle Q reads 1
//   FALL   out  one-cycle pulse, high in the first cycle Q reads 0
//   BUSY   out  high while a candidate change is being counted; this is the
//               FSM state register itself (1 = COUNT), so it doubles as the
//               state debug view

module pad_in_debounce #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 10,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic C,
    input  logic RD,
    input  logic PAD_I,
    input  logic CE,
    output logic Q,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [0:0]             state;
    logic [CW-1:0]          cnt;

    assign s    = sync[SYNC_STAGES-1];
    assign BUSY = (state == ST_COUNT);

    // The synchroniser runs every cycle, independent of CE. It reloads
    // RESET_LEVEL on reset so that release does not look like a pad edge.
    always_ff @(posedge C or negedge RD) begin
        if (!RD) begin
            sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], PAD_I};
        end
    end

    // IDLE : s matches Q and cnt is 0.
    // COUNT: s differs from Q and cnt holds the number of qualifying ticks so far.
    // Any cycle where s matches Q again drops the candidate, whatever CE is.
    always_ff @(posedge C or negedge RD) begin
        if (!RD) begin
            state <= ST_IDLE;
            cnt   <= '0;
            Q     <= RESET_LEVEL;
            RISE  <= 1'b0;
            FALL  <= 1'b0;
        end else begin
            RISE <= 1'b0;
            FALL <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if ((s != Q) && CE) begin
                        if (DEBOUNCE == 1) begin
                            // A single tick is enough: commit directly from IDLE.
                            Q    <= s;
                            RISE <= s;
                            FALL <= ~s;
                        end else begin
                            cnt   <= CW'(1);
                            state <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    if (s == Q) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (CE) begin
                        if (cnt == CW'(DEBOUNCE - 1)) begin
                            Q     <= s;
                            RISE  <= s;
                            FALL  <= ~s;
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
